// File: rtl/vlc_output_arbiter.sv
// vlc_output_arbiter: merges NUM_REQ VLC producer streams into one valid/ready
// bitstream-writer port. Per-port FIFOs absorb producer strobes; a round-robin
// scheduler grants a port and keeps it until its run ends (flush or idle).
// Optional feature macro: VLC_ARB_OVERFLOW_EN (sticky drop flag on 'overflow').
module vlc_output_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_enable,
  input  logic [NUM_REQ*DATA_W-1:0] req_val,
  input  logic [NUM_REQ*DATA_W-1:0] req_size,
  input  logic [NUM_REQ-1:0]        req_flush,
  input  logic                      out_ready,
  output logic                      output_enable,
  output logic [DATA_W-1:0]         val,
  output logic [DATA_W-1:0]         size_of_bit,
  output logic                      flush_bit,
  output logic [1:0]                grant_id,
  output logic [NUM_REQ-1:0]        fifo_full,
  output logic                      overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, LOCK} state_e;

  state_e            state_q, state_d;
  logic [1:0]        lock_q, lock_d;
  logic [1:0]        rr_q, rr_d;
  logic [1:0]        sel;
  logic              sel_valid;
  logic              can_load;
  logic              found;
  int unsigned       idx;
  logic [1:0]        cand;

  logic [NUM_REQ-1:0] empty;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic [DATA_W-1:0]  hval  [NUM_REQ];
  logic [DATA_W-1:0]  hsize [NUM_REQ];
  logic               hflush[NUM_REQ];

  logic              oe_q;
  logic [DATA_W-1:0] val_q, size_q;
  logic              flush_q;
  logic [1:0]        grant_q;

  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (32'(p) == NUM_REQ - 1) ? 2'd0 : p + 2'd1;
  endfunction

  assign can_load = !oe_q || out_ready;

  for (genvar p = 0; p < NUM_REQ; p++) begin : g_fifo
    logic [DATA_W-1:0] mval_q  [FIFO_DEPTH];
    logic [DATA_W-1:0] msize_q [FIFO_DEPTH];
    logic              mflush_q[FIFO_DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [AW:0]       cnt_q;

    assign fifo_full[p] = (cnt_q == DEPTH_C);
    assign empty[p]     = (cnt_q == '0);
    // a full FIFO still accepts when its head leaves in the same cycle
    assign push[p]      = req_enable[p] && (!fifo_full[p] || pop[p]);
    assign hval[p]      = mval_q[rptr_q];
    assign hsize[p]     = msize_q[rptr_q];
    assign hflush[p]    = mflush_q[rptr_q];

    // entry storage; validity is tracked by the pointers, so no reset needed
    always_ff @(posedge clock) begin
      if (push[p]) begin
        mval_q[wptr_q]   <= req_val[p*DATA_W +: DATA_W];
        msize_q[wptr_q]  <= req_size[p*DATA_W +: DATA_W];
        mflush_q[wptr_q] <= req_flush[p];
      end
    end

    // pointers and occupancy count
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push[p]) wptr_q <= wptr_q + 1'b1;
        if (pop[p])  rptr_q <= rptr_q + 1'b1;
        cnt_q <= cnt_q + (AW+1)'(push[p]) - (AW+1)'(pop[p]);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lock_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      rr_q    <= rr_d;
    end
  end

  // FSM next state: round-robin pick in IDLE, run ownership in LOCK
  always_comb begin
    state_d   = state_q;
    lock_d    = lock_q;
    rr_d      = rr_q;
    sel       = lock_q;
    sel_valid = 1'b0;
    found     = 1'b0;
    idx       = 0;
    cand      = '0;
    case (state_q)
      IDLE: begin
        if (can_load) begin
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(rr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = 2'(idx);
            if (!found && !empty[cand]) begin
              found = 1'b1;
              sel   = cand;
            end
          end
          sel_valid = found;
          if (found) begin
            if (hflush[sel]) begin
              rr_d = rr_next(sel);
            end else begin
              state_d = LOCK;
              lock_d  = sel;
            end
          end
        end
      end
      LOCK: begin
        if (empty[lock_q]) begin
          // release only when the producer has gone quiet; otherwise wait
          if (!req_enable[lock_q]) begin
            state_d = IDLE;
            rr_d    = rr_next(lock_q);
          end
        end else if (can_load) begin
          sel_valid = 1'b1;
          if (hflush[lock_q]) begin
            state_d = IDLE;
            rr_d    = rr_next(lock_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: pop strobe for the selected FIFO
  always_comb begin
    pop = '0;
    if (sel_valid) pop[sel] = 1'b1;
  end

  // output register: load on pop, hold under backpressure, clear when drained
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      oe_q    <= 1'b0;
      val_q   <= '0;
      size_q  <= '0;
      flush_q <= 1'b0;
      grant_q <= '0;
    end else if (sel_valid) begin
      oe_q    <= 1'b1;
      val_q   <= hval[sel];
      size_q  <= hsize[sel];
      flush_q <= hflush[sel];
      grant_q <= sel;
    end else if (can_load) begin
      oe_q    <= 1'b0;
      val_q   <= '0;
      size_q  <= '0;
      flush_q <= 1'b0;
      grant_q <= '0;
    end
  end

  assign output_enable = oe_q;
  assign val           = val_q;
  assign size_of_bit   = size_q;
  assign flush_bit     = flush_q;
  assign grant_id      = grant_q;

`ifdef VLC_ARB_OVERFLOW_EN
  logic [NUM_REQ-1:0] drop;
  logic               ovf_q;

  assign drop = req_enable & fifo_full & ~pop;

  // sticky drop indicator, cleared only by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      ovf_q <= 1'b0;
    else if (|drop) ovf_q <= 1'b1;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_vlc_output_arbiter.sv
// Scoreboard bench for vlc_output_arbiter: stimulus pushes hand-computed
// expected outputs; a negedge monitor compares the presented output entry.
module tb_vlc_output_arbiter;

  localparam int NR = 3;
  localparam int DW = 64;
`ifdef VLC_ARB_OVERFLOW_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_enable;
  logic [NR*DW-1:0]  req_val;
  logic [NR*DW-1:0]  req_size;
  logic [NR-1:0]     req_flush;
  logic              out_ready;
  logic              output_enable;
  logic [DW-1:0]     val;
  logic [DW-1:0]     size_of_bit;
  logic              flush_bit;
  logic [1:0]        grant_id;
  logic [NR-1:0]     fifo_full;
  logic              overflow;

  typedef struct {
    logic [63:0] v;
    logic [63:0] s;
    logic        f;
    logic [1:0]  g;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  vlc_output_arbiter #(.NUM_REQ(NR), .FIFO_DEPTH(4), .DATA_W(DW)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_enable   (req_enable),
    .req_val      (req_val),
    .req_size     (req_size),
    .req_flush    (req_flush),
    .out_ready    (out_ready),
    .output_enable(output_enable),
    .val          (val),
    .size_of_bit  (size_of_bit),
    .flush_bit    (flush_bit),
    .grant_id     (grant_id),
    .fifo_full    (fifo_full),
    .overflow     (overflow)
  );

  // monitor: every presented entry must match the scoreboard head
  always @(negedge clock) begin
    if (!reset && output_enable) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got g=%0d v=%h s=%h f=%b, required no output",
                 grant_id, val, size_of_bit, flush_bit);
      end else begin
        mon_e = sb[0];
        if (val !== mon_e.v || size_of_bit !== mon_e.s ||
            flush_bit !== mon_e.f || grant_id !== mon_e.g) begin
          n_fail++;
          $display("FAIL out_entry: got g=%0d v=%h s=%h f=%b, required g=%0d v=%h s=%h f=%b",
                   grant_id, val, size_of_bit, flush_bit,
                   mon_e.g, mon_e.v, mon_e.s, mon_e.f);
        end
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    req_enable = '0;
    req_val    = '0;
    req_size   = '0;
    req_flush  = '0;
  endtask

  task automatic set_port(input int p, input logic [63:0] v, input logic [63:0] s, input logic f);
    req_enable[p]        = 1'b1;
    req_val[p*DW +: DW]  = v;
    req_size[p*DW +: DW] = s;
    req_flush[p]         = f;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    clear_inputs();
  endtask

  task automatic expect_out(input logic [1:0] g, input logic [63:0] v, input logic [63:0] s, input logic f);
    exp_t e;
    e.g = g; e.v = v; e.s = s; e.f = f;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    out_ready = 1'b0;
    clear_inputs();
    @(posedge clock); #1;
    @(posedge clock); #1;
    sb.delete();
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(posedge clock); #1;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d entries outstanding, required 0", name, sb.size());
    end
    repeat (3) begin @(posedge clock); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_oe", output_enable, 0);
    chk("rst_val", val, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b0;

    // 1: single entry, latency and one-cycle pulse
    do_reset();
    out_ready = 1'b1;
    set_port(1, 64'd5, 64'd3, 1'b0);
    expect_out(2'd1, 64'd5, 64'd3, 1'b0);
    step();
    chk("t1_no_bypass", output_enable, 0);
    @(posedge clock); #1;
    chk("t1_oe", output_enable, 1);
    chk("t1_val", val, 64'd5);
    chk("t1_size", size_of_bit, 64'd3);
    chk("t1_grant", grant_id, 2'd1);
    @(posedge clock); #1;
    chk("t1_oe_pulse", output_enable, 0);
    drain("t1");

    // 2: run lock keeps port0 contiguous ahead of port1
    do_reset();
    out_ready = 1'b1;
    expect_out(2'd0, 64'hA0A0_0000_0000_000A, 64'd10, 1'b0);
    expect_out(2'd0, 64'hB0B0_0000_0000_000B, 64'd11, 1'b0);
    expect_out(2'd0, 64'hC0C0_0000_0000_000C, 64'd12, 1'b1);
    expect_out(2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd64, 1'b1);
    set_port(0, 64'hA0A0_0000_0000_000A, 64'd10, 1'b0);
    set_port(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd64, 1'b1);
    step();
    set_port(0, 64'hB0B0_0000_0000_000B, 64'd11, 1'b0);
    step();
    set_port(0, 64'hC0C0_0000_0000_000C, 64'd12, 1'b1);
    step();
    drain("t2");

    // 3: round robin from rr_ptr=0, then from rr_ptr=2
    do_reset();
    out_ready = 1'b1;
    for (int p = 0; p < NR; p++) begin
      set_port(p, 64'h30 + 64'(p), 64'd1 + 64'(p), 1'b1);
      expect_out(2'(p), 64'h30 + 64'(p), 64'd1 + 64'(p), 1'b1);
    end
    step();
    drain("t3a");
    set_port(1, 64'h41, 64'd7, 1'b1);
    expect_out(2'd1, 64'h41, 64'd7, 1'b1);
    step();
    drain("t3b");
    for (int p = 0; p < NR; p++) set_port(p, 64'h50 + 64'(p), 64'd20 + 64'(p), 1'b1);
    expect_out(2'd2, 64'h52, 64'd22, 1'b1);
    expect_out(2'd0, 64'h50, 64'd20, 1'b1);
    expect_out(2'd1, 64'h51, 64'd21, 1'b1);
    step();
    drain("t3c");

    // 4: backpressure holds the output and preserves order
    do_reset();
    out_ready = 1'b0;
    expect_out(2'd0, 64'h0123_4567_89AB_CDEF, 64'd33, 1'b0);
    expect_out(2'd0, 64'hDEAD_BEEF_0000_0001, 64'd17, 1'b0);
    expect_out(2'd0, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
    expect_out(2'd1, 64'h0000_0000_0000_0077, 64'd8, 1'b1);
    set_port(0, 64'h0123_4567_89AB_CDEF, 64'd33, 1'b0);
    set_port(1, 64'h0000_0000_0000_0077, 64'd8, 1'b1);
    step();
    set_port(0, 64'hDEAD_BEEF_0000_0001, 64'd17, 1'b0);
    step();
    set_port(0, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
    step();
    repeat (5) begin @(posedge clock); #1; end
    chk("t4_stall_oe", output_enable, 1);
    chk("t4_stall_val", val, 64'h0123_4567_89AB_CDEF);
    drain("t4");

    // 5: overflow on port2 while the output register is stalled
    do_reset();
    out_ready = 1'b0;
    set_port(0, 64'h99, 64'd9, 1'b1);
    expect_out(2'd0, 64'h99, 64'd9, 1'b1);
    step();
    @(posedge clock); #1;
    for (int i = 0; i < 5; i++) begin
      set_port(2, 64'hE0 + 64'(i), 64'd40 + 64'(i), (i >= 3));
      if (i < 4) expect_out(2'd2, 64'hE0 + 64'(i), 64'd40 + 64'(i), (i >= 3));
      step();
      if (i == 3) begin
        chk("t5_full", fifo_full, 3'b100);
        chk("t5_ovf_before", overflow, 0);
      end
    end
    @(posedge clock); #1;
    chk("t5_full_after", fifo_full, 3'b100);
    chk("t5_ovf", overflow, OVF_EXP);
    drain("t5");
    chk("t5_ovf_sticky", overflow, OVF_EXP);

    // 6: asynchronous reset while locked with queued entries
    do_reset();
    out_ready = 1'b0;
    expect_out(2'd0, 64'hAA, 64'd2, 1'b0);
    set_port(0, 64'hAA, 64'd2, 1'b0);
    step();
    set_port(0, 64'hBB, 64'd3, 1'b0);
    step();
    set_port(0, 64'hCC, 64'd4, 1'b1);
    step();
    chk("t6_pre_oe", output_enable, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_oe", output_enable, 0);
    chk("t6_rst_val", val, 0);
    chk("t6_rst_size", size_of_bit, 0);
    chk("t6_rst_flush", flush_bit, 0);
    chk("t6_rst_grant", grant_id, 0);
    chk("t6_rst_full", fifo_full, 0);
    chk("t6_rst_ovf", overflow, 0);
    sb.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (8) begin @(posedge clock); #1; end
    chk("t6_no_stale", output_enable, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
